// File: rtl/bram_rd_pkg.sv
// bram_rd_pkg: shared state type and default widths for the port-B stream reader.
package bram_rd_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 4;
   localparam int LEN_W_DEF  = ADDR_W_DEF + 1;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: small synchronous FIFO with clear; simultaneous push and pop allowed when full.
module bram_rd_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 5,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [CW-1:0]    count_o,
   output logic [WIDTH-1:0] head_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || clear_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= nxt(wr_q);
         end
         if (do_pop) rd_q <= nxt(rd_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/bram_s4_stream_reader.sv
// bram_s4_stream_reader: issues sequential port-B nibble reads for a (base, length)
// command and streams the data out on valid/ready, hiding the RAM's 1-cycle latency.
module bram_s4_stream_reader
   import bram_rd_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   len_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] addrb_o,
   output logic              enb_o,
   output logic              web_o,
   output logic              ssrb_o,
   input  logic [DATA_W-1:0] dob_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              dvalid_o,
   input  logic              dready_i,
   output logic              dlast_o
);
   localparam int LEN_W = ADDR_W + 1;
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q, issued_q, beats_q;
   logic              inflight_q, inflight_last_q, done_q, done_d;
   logic              run, accept, pop, push, clear, issue, last_beat, head_last;
   logic [CW-1:0]     fifo_cnt;
   logic [CW:0]       occ;

   assign run       = (state_q == RUN);
   assign accept    = (state_q == IDLE) && start_i && (len_i != '0);
   assign pop       = dvalid_o && dready_i;
   assign last_beat = pop && (beats_q == len_q - LEN_W'(1));
   // Occupancy counts the read already in flight so every issue has a reserved slot.
   assign occ       = (CW+1)'(fifo_cnt) + (CW+1)'(inflight_q) - (CW+1)'(pop);
   assign issue     = run && !abort_i && (issued_q != len_q) && (occ < (CW+1)'(FIFO_DEPTH));
   assign push      = inflight_q && run && !abort_i;
   assign clear     = run && abort_i;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (state_q == IDLE && start_i) begin
         state_d = (len_i == '0) ? IDLE : RUN;
         done_d  = (len_i == '0);
      end else if (run && abort_i) begin
         state_d = FLUSH;
      end else if (run && last_beat) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else if (state_q == FLUSH) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q         <= IDLE;
         done_q          <= 1'b0;
         addr_q          <= '0;
         len_q           <= '0;
         issued_q        <= '0;
         beats_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         done_q          <= done_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (issued_q == len_q - LEN_W'(1));
         if (accept) begin
            addr_q   <= base_addr_i;
            len_q    <= len_i;
            issued_q <= '0;
            beats_q  <= '0;
         end else begin
            if (issue) begin
               addr_q   <= addr_q + ADDR_W'(1);
               issued_q <= issued_q + LEN_W'(1);
            end
            if (pop) beats_q <= beats_q + LEN_W'(1);
         end
      end
   end

   bram_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W + 1)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (clear),
      .din_i   ({inflight_last_q, dob_i}),
      .count_o (fifo_cnt),
      .head_o  ({head_last, dout_o})
   );

   assign busy_o   = run;
   assign done_o   = done_q;
   assign addrb_o  = addr_q;
   assign enb_o    = issue;
   assign web_o    = 1'b0;
   assign ssrb_o   = 1'b0;
   assign dvalid_o = (fifo_cnt != '0);
   assign dlast_o  = dvalid_o && head_last;
endmodule

// File: tb/tb_bram_s4_stream_reader.sv
// tb_bram_s4_stream_reader: directed scenarios against a 4096x4 RAM model with mem[a] = a[3:0].
module tb_bram_s4_stream_reader;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dready = 1'b1;
   logic [11:0] base = '0, addrb;
   logic [12:0] len = '0;
   logic        busy, done, enb, web, ssrb, dvalid, dlast;
   logic [3:0]  dob = '0, dout;
   logic [3:0]  mem [4096];
   logic [3:0]  got [$];
   logic [11:0] addrs [$];
   logic [3:0]  prev_dout;
   logic        prev_stall = 1'b0, prev_last;
   int          total = 0, bad = 0, cyc = 0;
   int          enb_cnt, done_cnt, last_cnt, last_idx, start_c, first_v, last_c, done_c;
   int          stall_viol = 0, over = 0;

   bram_s4_stream_reader u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base), .len_i(len),
      .abort_i(abort), .busy_o(busy), .done_o(done), .addrb_o(addrb), .enb_o(enb),
      .web_o(web), .ssrb_o(ssrb), .dob_i(dob), .dout_o(dout), .dvalid_o(dvalid),
      .dready_i(dready), .dlast_o(dlast)
   );

   always #5 clk = ~clk;

   initial for (int a = 0; a < 4096; a++) mem[a] = 4'(a);
   always @(posedge clk) if (enb) dob <= mem[addrb];

   always @(negedge clk) begin
      cyc++;
      if (start && start_c < 0) start_c = cyc;
      if (dvalid && first_v < 0) first_v = cyc;
      if (dvalid && dready) begin
         got.push_back(dout);
         if (dlast) begin
            last_cnt++;
            last_idx = got.size() - 1;
            last_c   = cyc;
         end
      end
      if (enb) begin
         enb_cnt++;
         addrs.push_back(addrb);
      end
      if (done) begin
         done_cnt++;
         done_c = cyc;
      end
      if (prev_stall && !(dvalid && dout === prev_dout && dlast === prev_last)) stall_viol++;
      if (u_dut.fifo_cnt > 2'd2) over++;
      prev_stall = dvalid && !dready && !abort && rst_n;
      prev_dout  = dout;
      prev_last  = dlast;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input logic [3:0] v0, input int n);
      int e = 0;
      logic [3:0] v = v0;
      chk({tag, "_beats"}, got.size(), n);
      for (int i = 0; i < got.size() && i < n; i++) begin
         if (got[i] !== v) e++;
         v++;
      end
      chk({tag, "_data_errs"}, e, 0);
   endtask

   task automatic go(input logic [11:0] b, input logic [12:0] l);
      got.delete();
      addrs.delete();
      enb_cnt = 0; done_cnt = 0; last_cnt = 0; last_idx = -1;
      start_c = -1; first_v = -1; last_c = -1; done_c = -1;
      base = b; len = l; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit tog);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         if (tog) dready = ~dready;
         n++;
      end
      chk({tag, "_done_seen"}, done_cnt != 0, 1);
      dready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      logic [11:0] exp_a [4];
      int          e;
      exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_enb", enb, 0);
      chk("rst_dvalid", dvalid, 0);
      chk("rst_dlast", dlast, 0);
      chk("rst_addrb", addrb, 0);
      chk("rst_web_ssrb", {web, ssrb}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      go(12'h010, 13'd8);
      @(negedge clk);
      chk("s1_busy", busy, 1);
      wait_done("s1", 40, 1'b0);
      chk_seq("s1", 4'h0, 8);
      chk("s1_last_cnt", last_cnt, 1);
      chk("s1_last_idx", last_idx, 7);
      chk("s1_done_cnt", done_cnt, 1);
      chk("s1_enb_cnt", enb_cnt, 8);
      chk("s1_first_latency", first_v - start_c, 3);
      chk("s1_done_after_last", done_c - last_c, 1);
      chk("s1_no_bubbles", done_c - first_v, 8);
      chk("s1_busy_after", busy, 0);

      go(12'hFFE, 13'd4);
      wait_done("s2", 40, 1'b0);
      chk_seq("s2", 4'hE, 4);
      e = 0;
      for (int i = 0; i < 4 && i < addrs.size(); i++) if (addrs[i] !== exp_a[i]) e++;
      chk("s2_addr_n", addrs.size(), 4);
      chk("s2_addr_errs", e, 0);

      stall_viol = 0; over = 0;
      go(12'h020, 13'd16);
      wait_done("s3", 200, 1'b1);
      chk_seq("s3", 4'h0, 16);
      chk("s3_stall_viol", stall_viol, 0);
      chk("s3_fifo_over", over, 0);
      chk("s3_done_cnt", done_cnt, 1);
      chk("s3_last_idx", last_idx, 15);

      go(12'h000, 13'd4096);
      wait_done("s4", 5000, 1'b0);
      chk_seq("s4", 4'h0, 4096);
      chk("s4_last_cnt", last_cnt, 1);
      chk("s4_last_idx", last_idx, 4095);
      chk("s4_done_cnt", done_cnt, 1);
      chk("s4_enb_cnt", enb_cnt, 4096);

      go(12'h030, 13'd10);
      repeat (4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("s5_dvalid_off", dvalid, 0);
      chk("s5_enb_off", enb, 0);
      chk("s5_busy_flush", busy, 0);
      chk("s5_beats_before", got.size(), 3);
      chk("s5_enb_cnt", enb_cnt, 4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("s5_no_done", done_cnt, 0);
      chk("s5_dvalid_idle", dvalid, 0);
      @(posedge clk); #1;
      go(12'h030, 13'd10);
      wait_done("s5r", 60, 1'b0);
      chk_seq("s5r", 4'h0, 10);
      chk("s5r_done_cnt", done_cnt, 1);

      go(12'h100, 13'd0);
      repeat (3) begin @(posedge clk); #1; end
      chk("s6_len0_done", done_cnt, 1);
      chk("s6_len0_done_lat", done_c - start_c, 1);
      chk("s6_len0_enb", enb_cnt, 0);

      go(12'h100, 13'd16);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("s6_rst_outs", {busy, done, enb, dvalid, dlast}, 0);
      chk("s6_rst_addrb", addrb, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      go(12'h005, 13'd3);
      wait_done("s6r", 40, 1'b0);
      chk_seq("s6r", 4'h5, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
